note_draw_sequencer: RTL and testbench

- Accepts one "display note" request (note code, octave, anchor x/y) and sequences every framebuffer pixel write needed to show it.
- Blanks a 36x12 region, then plots three 12x12 glyphs side by side: sharp at x+0, letter at x+12, octave digit at x+24.
- Sits between note-detection logic and the VGA adapter's pixel-write port (x, y, colour, writeEn).
- Replaces free-running per-glyph drawing with one arbitrated, handshaked pixel stream.

---
 rtl/note_glyph_pkg.sv | 236 +++++++++++++++++++++++
 rtl/glyph_walker.sv | 35 +++
 rtl/note_draw_sequencer.sv | 169 ++++++++++++++++
 tb/tb_note_draw_sequencer.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/note_glyph_pkg.sv
// Glyph bitmaps, sequencer state encoding and note decoding shared by the note drawing logic.
// Rows are listed top to bottom; the MSB of each 144-bit glyph is the top-left pixel.
package note_glyph_pkg;

    localparam int GLYPH_SIDE  = 12;
    localparam int GLYPH_BITS  = GLYPH_SIDE * GLYPH_SIDE;
    localparam int TILE_STRIDE = GLYPH_SIDE;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLR0,
        ST_CLR1,
        ST_CLR2,
        ST_SHARP,
        ST_LETTER,
        ST_OCT
    } state_t;

    localparam logic [GLYPH_BITS-1:0] GLYPH_A = {
        12'b000000000000,
        12'b000011110000,
        12'b000110011000,
        12'b001100001100,
        12'b001100001100,
        12'b001111111100,
        12'b001100001100,
        12'b001100001100,
        12'b001100001100,
        12'b001100001100,
        12'b001100001100,
        12'b000000000000
    };

    localparam logic [GLYPH_BITS-1:0] GLYPH_B = {
        12'b000000000000,
        12'b001111110000,
        12'b001100011000,
        12'b001100011000,
        12'b001111110000,
        12'b001100011000,
        12'b001100001100,
        12'b001100001100,
        12'b001100011000,
        12'b001111110000,
        12'b000000000000,
        12'b000000000000
    };

    localparam logic [GLYPH_BITS-1:0] GLYPH_C = {
        12'b000000000000,
        12'b000011111000,
        12'b000110000000,
        12'b001100000000,
        12'b001100000000,
        12'b001100000000,
        12'b001100000000,
        12'b001100000000,
        12'b001100000000,
        12'b000110000000,
        12'b000011111000,
        12'b000000000000
    };

    localparam logic [GLYPH_BITS-1:0] GLYPH_D = {
        12'b000000000000,
        12'b001111100000,
        12'b001100110000,
        12'b001100011000,
        12'b001100001100,
        12'b001100001100,
        12'b001100001100,
        12'b001100001100,
        12'b001100011000,
        12'b001100110000,
        12'b001111100000,
        12'b000000000000
    };

    localparam logic [GLYPH_BITS-1:0] GLYPH_E = {
        12'b000000000000,
        12'b001111111100,
        12'b001100000000,
        12'b001100000000,
        12'b001100000000,
        12'b001111110000,
        12'b001100000000,
        12'b001100000000,
        12'b001100000000,
        12'b001100000000,
        12'b001111111100,
        12'b000000000000
    };

    localparam logic [GLYPH_BITS-1:0] GLYPH_F = {
        12'b000000000000,
        12'b001111111100,
        12'b001100000000,
        12'b001100000000,
        12'b001100000000,
        12'b001111110000,
        12'b001100000000,
        12'b001100000000,
        12'b001100000000,
        12'b001100000000,
        12'b001100000000,
        12'b000000000000
    };

    localparam logic [GLYPH_BITS-1:0] GLYPH_G = {
        12'b000000000000,
        12'b000011111000,
        12'b000110000000,
        12'b001100000000,
        12'b001100000000,
        12'b001100111100,
        12'b001100001100,
        12'b001100001100,
        12'b000110001100,
        12'b000011111100,
        12'b000000000000,
        12'b000000000000
    };

    localparam logic [GLYPH_BITS-1:0] GLYPH_SHARP = {
        12'b000000000000,
        12'b001000010000,
        12'b001000010000,
        12'b111111111110,
        12'b001000010000,
        12'b001000010000,
        12'b001000010000,
        12'b111111111110,
        12'b001000010000,
        12'b001000010000,
        12'b001000010000,
        12'b000000000000
    };

    localparam logic [GLYPH_BITS-1:0] GLYPH_DIGIT1 = {
        12'b000000000000,
        12'b000001100000,
        12'b000011100000,
        12'b000111100000,
        12'b000001100000,
        12'b000001100000,
        12'b000001100000,
        12'b000001100000,
        12'b000001100000,
        12'b000001100000,
        12'b000111111000,
        12'b000000000000
    };

    localparam logic [GLYPH_BITS-1:0] GLYPH_DIGIT2 = {
        12'b000000000000,
        12'b000111110000,
        12'b001100011000,
        12'b000000011000,
        12'b000000110000,
        12'b000001100000,
        12'b000011000000,
        12'b000110000000,
        12'b001100000000,
        12'b001111111000,
        12'b000000000000,
        12'b000000000000
    };

    localparam logic [GLYPH_BITS-1:0] GLYPH_DIGIT3 = {
        12'b000000000000,
        12'b001111110000,
        12'b000000011000,
        12'b000000011000,
        12'b000011110000,
        12'b000000011000,
        12'b000000001100,
        12'b000000001100,
        12'b000000011000,
        12'b001111110000,
        12'b000000000000,
        12'b000000000000
    };

    localparam logic [GLYPH_BITS-1:0] GLYPH_DIGIT4 = {
        12'b000000000000,
        12'b001000110000,
        12'b001000110000,
        12'b001000110000,
        12'b001000110000,
        12'b001111111100,
        12'b000000110000,
        12'b000000110000,
        12'b000000110000,
        12'b000000110000,
        12'b000000110000,
        12'b000000000000
    };

    typedef struct packed {
        logic [GLYPH_BITS-1:0] letter;
        logic                  has_sharp;
    } note_dec_t;

    // Unknown codes decode to a blank letter with no sharp.
    function automatic note_dec_t decode_note(input logic [3:0] code);
        note_dec_t d;
        d.letter    = '0;
        d.has_sharp = 1'b0;
        case (code)
            4'd1:  d.letter = GLYPH_A;
            4'd2:  begin d.letter = GLYPH_A; d.has_sharp = 1'b1; end
            4'd3:  d.letter = GLYPH_B;
            4'd4:  d.letter = GLYPH_C;
            4'd5:  begin d.letter = GLYPH_C; d.has_sharp = 1'b1; end
            4'd6:  d.letter = GLYPH_D;
            4'd7:  begin d.letter = GLYPH_D; d.has_sharp = 1'b1; end
            4'd8:  d.letter = GLYPH_E;
            4'd9:  d.letter = GLYPH_F;
            4'd10: begin d.letter = GLYPH_F; d.has_sharp = 1'b1; end
            4'd11: d.letter = GLYPH_G;
            4'd12: begin d.letter = GLYPH_G; d.has_sharp = 1'b1; end
            default: ;
        endcase
        return d;
    endfunction

    function automatic logic [GLYPH_BITS-1:0] octave_glyph(input logic [1:0] oct);
        case (oct)
            2'd0:    return GLYPH_DIGIT1;
            2'd1:    return GLYPH_DIGIT2;
            2'd2:    return GLYPH_DIGIT3;
            default: return GLYPH_DIGIT4;
        endcase
    endfunction

endpackage

// File: rtl/glyph_walker.sv
// Row-major col/row scanner over one DIM x DIM tile; wraps to 0,0 after the last pixel.
module glyph_walker #(
    parameter int DIM = 12
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic       clr,
    output logic [3:0] col,
    output logic [3:0] row,
    output logic       last_pixel
);

    localparam logic [3:0] LAST = 4'(DIM - 1);

    assign last_pixel = (col == LAST) && (row == LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            col <= '0;
            row <= '0;
        end else if (clr) begin
            col <= '0;
            row <= '0;
        end else if (en) begin
            if (col == LAST) begin
                col <= '0;
                row <= (row == LAST) ? 4'd0 : row + 4'd1;
            end else begin
                col <= col + 4'd1;
            end
        end
    end

endmodule

// File: rtl/note_draw_sequencer.sv
// Turns one note request into a blank-then-draw pixel stream for three 12x12 tiles.
// Optional build macro NOTE_DRAW_SKIP_BLANK_EN skips glyph tiles whose glyph is all-zero.
module note_draw_sequencer #(
    parameter int         GLYPH_DIM = 12,
    parameter logic [2:0] FG_COLOUR = 3'b010,
    parameter logic [2:0] BG_COLOUR = 3'b000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [3:0] note,
    input  logic [1:0] octave,
    input  logic [7:0] x,
    input  logic [6:0] y,
    output logic [7:0] x_out,
    output logic [6:0] y_out,
    output logic [2:0] colour,
    output logic       writeEn,
    output logic       busy,
    output logic       done
);

    import note_glyph_pkg::*;

    localparam logic [7:0] OFF1 = 8'(TILE_STRIDE);
    localparam logic [7:0] OFF2 = 8'(2 * TILE_STRIDE);

    state_t     state;
    state_t     nxt;
    state_t     px_state;
    logic [3:0] note_q;
    logic [1:0] oct_q;
    logic [7:0] x_q;
    logic [6:0] y_q;

    logic       accept;
    logic       walk_en;
    logic       walk_clr;
    logic [3:0] col;
    logic [3:0] row;
    logic       last_pixel;

    note_dec_t             dec;
    logic [GLYPH_BITS-1:0] glyph;
    logic                  skip_sharp;
    logic                  skip_letter;
    logic                  is_clear;
    logic [7:0]            bit_idx;
    logic [7:0]            tile_off;
    logic [7:0]            base_x;
    logic [6:0]            base_y;
    logic [7:0]            px_x;
    logic [6:0]            px_y;
    logic                  px_we;
    logic [2:0]            px_colour;

    // req_ready low while IDLE marks the completion cycle, so no request is taken then.
    assign accept   = (state == ST_IDLE) && req_ready && req_valid;
    assign walk_en  = accept || (state != ST_IDLE);
    assign walk_clr = (state == ST_IDLE) && !accept;
    assign dec      = decode_note(note_q);

`ifdef NOTE_DRAW_SKIP_BLANK_EN
    assign skip_sharp  = !dec.has_sharp;
    assign skip_letter = (dec.letter == '0);
`else
    assign skip_sharp  = 1'b0;
    assign skip_letter = 1'b0;
`endif

    glyph_walker #(.DIM(GLYPH_DIM)) u_walker (
        .clk        (clk),
        .reset      (reset),
        .en         (walk_en),
        .clr        (walk_clr),
        .col        (col),
        .row        (row),
        .last_pixel (last_pixel)
    );

    always_comb begin
        nxt = ST_IDLE;
        case (state)
            ST_CLR0:   nxt = ST_CLR1;
            ST_CLR1:   nxt = ST_CLR2;
            ST_CLR2:   nxt = !skip_sharp ? ST_SHARP : (!skip_letter ? ST_LETTER : ST_OCT);
            ST_SHARP:  nxt = !skip_letter ? ST_LETTER : ST_OCT;
            ST_LETTER: nxt = ST_OCT;
            default:   nxt = ST_IDLE;
        endcase
    end

    // The pixel presented next cycle; on acceptance it is CLR0 (0,0) taken straight from the inputs.
    always_comb begin
        px_state = accept ? ST_CLR0 : state;
        base_x   = accept ? x : x_q;
        base_y   = accept ? y : y_q;
        case (px_state)
            ST_CLR1, ST_LETTER: tile_off = OFF1;
            ST_CLR2, ST_OCT:    tile_off = OFF2;
            default:            tile_off = 8'd0;
        endcase
        case (px_state)
            ST_SHARP:  glyph = dec.has_sharp ? GLYPH_SHARP : '0;
            ST_LETTER: glyph = dec.letter;
            ST_OCT:    glyph = octave_glyph(oct_q);
            default:   glyph = '0;
        endcase
        is_clear  = (px_state == ST_CLR0) || (px_state == ST_CLR1) || (px_state == ST_CLR2);
        bit_idx   = 8'(GLYPH_BITS - 1) - (8'(row) * 8'(GLYPH_DIM) + 8'(col));
        px_we     = is_clear || glyph[bit_idx];
        px_colour = (px_we && !is_clear) ? FG_COLOUR : BG_COLOUR;
        px_x      = base_x + tile_off + 8'(col);
        px_y      = base_y + 7'(row);
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            note_q <= note;
            oct_q  <= octave;
            x_q    <= x;
            y_q    <= y;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= ST_IDLE;
            req_ready <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b0;
            writeEn   <= 1'b0;
            colour    <= '0;
            x_out     <= '0;
            y_out     <= '0;
        end else begin
            done <= 1'b0;
            if (state == ST_IDLE) begin
                if (!req_ready) begin
                    req_ready <= 1'b1;
                    busy      <= 1'b0;
                    done      <= 1'b1;
                    writeEn   <= 1'b0;
                    colour    <= '0;
                    x_out     <= '0;
                    y_out     <= '0;
                end else if (req_valid) begin
                    state     <= ST_CLR0;
                    req_ready <= 1'b0;
                    busy      <= 1'b1;
                    writeEn   <= px_we;
                    colour    <= px_colour;
                    x_out     <= px_x;
                    y_out     <= px_y;
                end
            end else begin
                writeEn <= px_we;
                colour  <= px_colour;
                x_out   <= px_x;
                y_out   <= px_y;
                if (last_pixel) begin
                    state <= nxt;
                end
            end
        end
    end

endmodule

// File: tb/tb_note_draw_sequencer.sv
// Scoreboard bench for note_draw_sequencer: planned pixel writes and busy windows are queued per request.
module tb_note_draw_sequencer;
    import note_glyph_pkg::*;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       req_valid = 1'b0;
    logic       req_ready;
    logic [3:0] note = '0;
    logic [1:0] octave = '0;
    logic [7:0] x = '0;
    logic [6:0] y = '0;
    logic [7:0] x_out;
    logic [6:0] y_out;
    logic [2:0] colour;
    logic       writeEn;
    logic       busy;
    logic       done;

    note_draw_sequencer dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .note(note), .octave(octave), .x(x), .y(y),
        .x_out(x_out), .y_out(y_out), .colour(colour), .writeEn(writeEn),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int c;
        int px;
        int py;
        int col;
    } wr_t;

    wr_t wq[$];
    int  win_s[$];
    int  win_e[$];
    int  free_cycle = 0;
    bit  in_reset = 1'b1;
    int  checks = 0;
    int  passes = 0;

    function automatic void check(string name, int act, int exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    endfunction

    function automatic bit gbit(logic [143:0] g, int r, int c);
        return g[143 - (r * 12 + c)];
    endfunction

    function automatic logic [143:0] letter_glyph(int n);
        string names = "AABCCDDEFFGG";
        byte   ch;
        if (n < 1 || n > 12) return '0;
        ch = names[n - 1];
        case (ch)
            "A": return GLYPH_A;
            "B": return GLYPH_B;
            "C": return GLYPH_C;
            "D": return GLYPH_D;
            "E": return GLYPH_E;
            "F": return GLYPH_F;
            "G": return GLYPH_G;
            default: return '0;
        endcase
    endfunction

    function automatic logic [143:0] digit_glyph(int o);
        case (o)
            0: return GLYPH_DIGIT1;
            1: return GLYPH_DIGIT2;
            2: return GLYPH_DIGIT3;
            default: return GLYPH_DIGIT4;
        endcase
    endfunction

    // Reference: three blank tiles then up to three glyph tiles, one pixel per cycle from a+1.
    function automatic void plan(int n, int o, int xx, int yy, int a);
        logic [143:0] g[3];
        int k = 0;
        bit drawn;
        g[0] = (n == 2 || n == 5 || n == 7 || n == 10 || n == 12) ? GLYPH_SHARP : '0;
        g[1] = letter_glyph(n);
        g[2] = digit_glyph(o);
        for (int t = 0; t < 3; t++)
            for (int r = 0; r < 12; r++)
                for (int c = 0; c < 12; c++) begin
                    wq.push_back('{a + 1 + k, (xx + 12 * t + c) % 256, (yy + r) % 128, 0});
                    k++;
                end
        for (int t = 0; t < 3; t++) begin
            drawn = 1'b1;
`ifdef NOTE_DRAW_SKIP_BLANK_EN
            drawn = (g[t] != '0);
`endif
            if (drawn)
                for (int r = 0; r < 12; r++)
                    for (int c = 0; c < 12; c++) begin
                        if (gbit(g[t], r, c))
                            wq.push_back('{a + 1 + k, (xx + 12 * t + c) % 256, (yy + r) % 128, 2});
                        k++;
                    end
        end
        win_s.push_back(a + 1);
        win_e.push_back(a + k);
        free_cycle = a + k + 1;
    endfunction

    always @(negedge clk) begin
        int be;
        int de;
        if (in_reset) begin
            check("reset_state", int'({req_ready, busy, done, writeEn, colour, x_out, y_out}), 1 << 21);
        end else begin
            be = 0;
            de = 0;
            foreach (win_s[i]) begin
                if (cyc >= win_s[i] && cyc <= win_e[i]) be = 1;
                if (cyc == win_e[i] + 1) de = 1;
            end
            while (win_e.size() > 0 && win_e[0] + 1 < cyc) begin
                void'(win_s.pop_front());
                void'(win_e.pop_front());
            end
            check("ctrl_busy_ready_done", int'({busy, req_ready, done}), (be << 2) | ((1 - be) << 1) | de);
            if (writeEn) begin
                if (wq.size() == 0) begin
                    checks++;
                    $display("FAIL unexpected_write: got write at (%0d,%0d) expected none (cycle %0d)", x_out, y_out, cyc);
                end else begin
                    wr_t w;
                    w = wq.pop_front();
                    check("write_cycle", cyc, w.c);
                    check("write_xy", int'(x_out) * 128 + int'(y_out), w.px * 128 + w.py);
                    check("write_colour", int'(colour), w.col);
                end
            end else if (wq.size() > 0 && wq[0].c <= cyc) begin
                checks++;
                $display("FAIL missing_write: got writeEn=0 expected write at (%0d,%0d) (cycle %0d)", wq[0].px, wq[0].py, cyc);
                void'(wq.pop_front());
            end
        end
    end

    task automatic issue(input int n, input int o, input int xx, input int yy, output int a);
        note      = 4'(n);
        octave    = 2'(o);
        x         = 8'(xx);
        y         = 7'(yy);
        req_valid = 1'b1;
        a = (cyc > free_cycle) ? cyc : free_cycle;
        plan(n, o, xx, yy, a);
        while (cyc < a) begin @(posedge clk); #1; end
        @(posedge clk); #1;
        req_valid = 1'b0;
        note      = 4'($urandom);
        octave    = 2'($urandom);
        x         = 8'($urandom);
        y         = 7'($urandom);
    endtask

    task automatic peek(string name, int target, int we, int xx, int yy, int col);
        @(negedge clk);
        while (cyc < target) @(negedge clk);
        check(name, int'({writeEn, colour, x_out, y_out}), (we << 18) | (col << 15) | (xx << 7) | yy);
    endtask

    task automatic settle();
        @(posedge clk); #1;
        while (cyc < free_cycle + 2) begin @(posedge clk); #1; end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int a;
        int a2;
        int oct_start;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        in_reset = 1'b0;
        free_cycle = cyc;
        repeat (2) @(posedge clk);
        #1;

        issue(5, 2, 10, 20, a);
        peek("first_pixel", a + 1, 1, 10, 20, 0);
        peek("last_blank", a + 432, 1, 45, 31, 0);
        peek("sharp_r1c1_clear", a + 446, 0, 11, 21, 0);
        peek("sharp_r1c2_set", a + 447, 1, 12, 21, 2);
        settle();

        issue(0, 3, 0, 0, a);
`ifdef NOTE_DRAW_SKIP_BLANK_EN
        oct_start = a + 432;
`else
        oct_start = a + 720;
`endif
        peek("oct4_first_set", oct_start + 15, 1, 26, 1, 2);
        settle();

        issue(1, 0, 250, 120, a);
        settle();

        issue(7, 1, 60, 30, a);
        issue(12, 2, 100, 90, a2);
        settle();

        issue(14, 1, 5, 5, a);
        settle();

        issue(3, 1, 40, 50, a);
        while (cyc < a + 300) begin @(posedge clk); #1; end
        reset = 1'b0;
        in_reset = 1'b1;
        wq.delete();
        win_s.delete();
        win_e.delete();
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        in_reset = 1'b0;
        free_cycle = cyc;
        repeat (30) @(posedge clk);
        #1;

        for (int i = 0; i < 6; i++) begin
            repeat ($urandom_range(0, 4)) @(posedge clk);
            #1;
            issue(int'($urandom_range(0, 15)), int'($urandom_range(0, 3)),
                  int'($urandom_range(0, 255)), int'($urandom_range(0, 127)), a);
        end
        settle();

        check("queue_drained", wq.size(), 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
